// File: rtl/sat9_rr_sched.sv
// Round-robin scheduler sharing one registered 13->9 bit symmetric I/Q saturator
// between NCH requesters, each with a 1-deep holding register.
module sat9_rr_sched #(
  parameter int NCH  = 2,
  parameter int CHW  = 2,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [13*NCH-1:0]   req_i,
  input  logic [13*NCH-1:0]   req_q,
  input  logic [NCH-1:0]      req_valid,
  output logic [NCH-1:0]      req_ready,
  output logic [8:0]          out_i,
  output logic [8:0]          out_q,
  output logic                out_en,
  output logic [CHW-1:0]      out_ch,
  output logic [CNTW-1:0]     sat_cnt,
  input  logic                clr_cnt,
  output logic                busy
);

  // Clip to the symmetric range -255..+255; -256 also maps to 9'h101.
  function automatic logic [8:0] sat9(input logic signed [12:0] x);
    logic [8:0] r;
    if (x > 13'sd255) begin
      r = 9'h0FF;
    end else if (x < -13'sd255) begin
      r = 9'h101;
    end else begin
      r = x[8:0];
    end
    return r;
  endfunction

  function automatic logic clip9(input logic signed [12:0] x);
    return (x > 13'sd255) || (x < -13'sd255);
  endfunction

  logic [NCH-1:0]  full_r;
  logic [12:0]     hold_i_r [NCH];
  logic [12:0]     hold_q_r [NCH];
  logic [CHW-1:0]  last_r;
  logic [8:0]      out_i_r;
  logic [8:0]      out_q_r;
  logic            out_en_r;
  logic [CHW-1:0]  out_ch_r;
  logic [CNTW-1:0] sat_cnt_r;

  logic [NCH-1:0]  grant_s;
  logic [NCH-1:0]  ready_s;
  logic [NCH-1:0]  accept_s;
  logic            found_s;
  logic [CHW-1:0]  gnt_ch_s;
  logic [12:0]     gnt_i_s;
  logic [12:0]     gnt_q_s;
  logic            clip_s;
  int              idx_s;

  // Round-robin arbiter: scan from last+1, first full holding register wins.
  always_comb begin
    grant_s  = '0;
    found_s  = 1'b0;
    gnt_ch_s = '0;
    gnt_i_s  = 13'd0;
    gnt_q_s  = 13'd0;
    idx_s    = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx_s = (int'(last_r) + k) % NCH;
      if (!found_s && full_r[idx_s]) begin
        found_s        = 1'b1;
        grant_s[idx_s] = 1'b1;
        gnt_ch_s       = CHW'(idx_s);
        gnt_i_s        = hold_i_r[idx_s];
        gnt_q_s        = hold_q_r[idx_s];
      end else begin
        found_s = found_s;
      end
    end
  end

  // A register being drained this cycle may be refilled on the same edge.
  always_comb begin
    ready_s  = ~full_r | grant_s;
    accept_s = req_valid & ready_s;
    clip_s   = clip9($signed(gnt_i_s)) | clip9($signed(gnt_q_s));
  end

  // Per-channel holding registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      full_r <= '0;
      for (int c = 0; c < NCH; c++) begin
        hold_i_r[c] <= 13'd0;
        hold_q_r[c] <= 13'd0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (accept_s[c]) begin
          full_r[c]   <= 1'b1;
          hold_i_r[c] <= req_i[13*c +: 13];
          hold_q_r[c] <= req_q[13*c +: 13];
        end else if (grant_s[c]) begin
          full_r[c] <= 1'b0;
        end
      end
    end
  end

  // Registered saturation stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      last_r   <= CHW'(NCH - 1);
      out_en_r <= 1'b0;
      out_i_r  <= 9'd0;
      out_q_r  <= 9'd0;
      out_ch_r <= '0;
    end else if (found_s) begin
      last_r   <= gnt_ch_s;
      out_en_r <= 1'b1;
      out_i_r  <= sat9($signed(gnt_i_s));
      out_q_r  <= sat9($signed(gnt_q_s));
      out_ch_r <= gnt_ch_s;
    end else begin
      out_en_r <= 1'b0;
      out_i_r  <= 9'd0;
      out_q_r  <= 9'd0;
    end
  end

  // Sticky saturation-event counter; clear wins over a simultaneous event.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sat_cnt_r <= '0;
    end else if (clr_cnt) begin
      sat_cnt_r <= '0;
    end else if (found_s && clip_s && (sat_cnt_r != {CNTW{1'b1}})) begin
      sat_cnt_r <= sat_cnt_r + CNTW'(1);
    end
  end

  assign req_ready = ready_s;
  assign busy      = |full_r;
  assign out_i     = out_i_r;
  assign out_q     = out_q_r;
  assign out_en    = out_en_r;
  assign out_ch    = out_ch_r;
  assign sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_sat9_rr_sched.sv
// Randomized scoreboard bench for sat9_rr_sched: a queue-based reference model
// predicts grants, readiness, saturated outputs and the event counter.
module tb_sat9_rr_sched;
  localparam int NCH  = 2;
  localparam int CHW  = 2;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rstb;
  logic [13*NCH-1:0] req_i;
  logic [13*NCH-1:0] req_q;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [8:0]        out_i;
  logic [8:0]        out_q;
  logic              out_en;
  logic [CHW-1:0]    out_ch;
  logic [CNTW-1:0]   sat_cnt;
  logic              clr_cnt;
  logic              busy;

  sat9_rr_sched #(.NCH(NCH), .CHW(CHW), .CNTW(CNTW)) dut (
    .clk(clk), .rstb(rstb), .req_i(req_i), .req_q(req_q), .req_valid(req_valid),
    .req_ready(req_ready), .out_i(out_i), .out_q(out_q), .out_en(out_en),
    .out_ch(out_ch), .sat_cnt(sat_cnt), .clr_cnt(clr_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [8:0] i;
    logic [8:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  // reference model state
  bit   m_full[NCH];
  int   m_i[NCH];
  int   m_q[NCH];
  int   m_last;
  int   m_cnt;
  int   idle_ch;
  int   stim_i[NCH];
  int   stim_q[NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int msat(input int x);
    if (x > 255) return 255;
    if (x < -255) return -255;
    return x;
  endfunction

  function automatic bit mclip(input int x);
    return (x > 255) || (x < -255);
  endfunction

  // One clock cycle: drive inputs, check readiness, advance the reference model.
  task automatic step(input logic [NCH-1:0] v, input logic clr, input logic rb);
    int g;
    bit exp_rdy[NCH];
    bit any_full;
    @(negedge clk);
    #1;
    rstb      = rb;
    clr_cnt   = clr;
    req_valid = v;
    for (int c = 0; c < NCH; c++) begin
      req_i[13*c +: 13] = 13'(stim_i[c]);
      req_q[13*c +: 13] = 13'(stim_q[c]);
    end
    #1;
    if (!rb) begin
      for (int c = 0; c < NCH; c++) m_full[c] = 1'b0;
      m_last  = NCH - 1;
      m_cnt   = 0;
      idle_ch = 0;
      sb.delete();
    end else begin
      g = -1;
      any_full = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        if (g < 0 && m_full[(m_last + k) % NCH]) g = (m_last + k) % NCH;
      end
      for (int c = 0; c < NCH; c++) begin
        exp_rdy[c] = !m_full[c] || (g == c);
        any_full   = any_full | m_full[c];
        chk($sformatf("req_ready[%0d]", c), 32'(req_ready[c]), 32'(exp_rdy[c]));
      end
      chk("busy", 32'(busy), 32'(any_full));
      if (g >= 0) begin
        sb.push_back('{ch: g, i: 9'(msat(m_i[g])), q: 9'(msat(m_q[g]))});
        if (!clr && (mclip(m_i[g]) || mclip(m_q[g])) && m_cnt < CMAX) m_cnt++;
        m_last    = g;
        m_full[g] = 1'b0;
      end
      if (clr) m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
        if (v[c] && exp_rdy[c]) begin
          m_full[c] = 1'b1;
          m_i[c]    = stim_i[c];
          m_q[c]    = stim_q[c];
        end
      end
    end
  endtask

  // Monitor: every presented output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      if (out_en) begin
        if (sb.size() == 0) begin
          chk("unexpected out_en", 32'(out_en), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("out_i", 32'(out_i), 32'(e.i));
          chk("out_q", 32'(out_q), 32'(e.q));
          idle_ch = e.ch;
        end
      end else begin
        chk("missing output", 32'(sb.size()), 32'd0);
        chk("idle out_i", 32'(out_i), 32'd0);
        chk("idle out_q", 32'(out_q), 32'd0);
        chk("idle out_ch", 32'(out_ch), 32'(idle_ch));
      end
      chk("sat_cnt", 32'(sat_cnt), 32'(m_cnt));
    end
  end

  function automatic int rnd_sample();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 8191)) - 4096;
      1: return int'($urandom_range(250, 260));
      2: return -int'($urandom_range(250, 260));
      default: return int'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  task automatic set_ch(input int c, input int i, input int q);
    stim_i[c] = i;
    stim_q[c] = q;
  endtask

  initial begin
    rstb = 1'b0; clr_cnt = 1'b0; req_valid = '0; req_i = '0; req_q = '0;
    for (int c = 0; c < NCH; c++) set_ch(c, 0, 0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    mon_on = 1'b1;
    step('0, 1'b0, 1'b1);
    // single channel, no clipping
    set_ch(0, 100, -100);
    step(2'b01, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
    // channel 1 clipping, including -256 and +255
    set_ch(1, 300, -300);
    step(2'b10, 1'b0, 1'b1);
    set_ch(1, -256, 255);
    step(2'b10, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
    // reset, then both filled on the same edge
    step('0, 1'b0, 1'b0);
    set_ch(0, 10, 11); set_ch(1, 20, 21);
    step(2'b11, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
    // both continuously valid with ramps
    for (int n = 0; n < 24; n++) begin
      set_ch(0, n * 17 - 200, -n * 13);
      set_ch(1, 4000 - n * 300, n * 25);
      step(2'b11, 1'b0, 1'b1);
    end
    // reset with both holds full
    step('0, 1'b0, 1'b0);
    repeat (2) step('0, 1'b0, 1'b1);
    // drive the counter to saturation, then clear with a clip on the same edge
    for (int n = 0; n < CMAX + 20; n++) begin
      set_ch(0, 1000, 0); set_ch(1, -7, -2000);
      step(2'b11, 1'b0, 1'b1);
    end
    step(2'b11, 1'b1, 1'b1);
    repeat (4) step(2'b11, 1'b0, 1'b1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, rnd_sample(), rnd_sample());
      step(NCH'($urandom_range(0, (1 << NCH) - 1)), ($urandom_range(0, 99) == 0),
           !($urandom_range(0, 299) == 0));
    end
    repeat (5) step('0, 1'b0, 1'b1);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
